// File: rtl/pattern_fsm_pkg.sv
// pattern_fsm_pkg
//   Shared definitions for the pattern_fsm detector: one-hot state
//   constants, the 2-bit encoded state codes exposed on state_out, the
//   encode helper, and the supported range of the pattern length.
//   Ports: none (package).
package pattern_fsm_pkg;

  localparam int LEN_MIN = 2;
  localparam int LEN_MAX = 16;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_FILL  = 4'b0010;
  localparam logic [3:0] ST_ARMED = 4'b0100;
  localparam logic [3:0] ST_HIT   = 4'b1000;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_FILL  = 2'd1;
  localparam logic [1:0] ENC_ARMED = 2'd2;
  localparam logic [1:0] ENC_HIT   = 2'd3;

  // Non-one-hot values report as IDLE; the FSM recovers from them on the
  // next edge anyway.
  function automatic logic [1:0] encode_state(input logic [3:0] st);
    logic [1:0] code;
    case (st)
      ST_FILL:  code = ENC_FILL;
      ST_ARMED: code = ENC_ARMED;
      ST_HIT:   code = ENC_HIT;
      default:  code = ENC_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pattern_fsm_window.sv
// pattern_fsm_window
//   Serial window of the detector: LEN-bit shift register (new bit into
//   the LSB), saturating fill counter and the look-ahead pattern compare.
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     clr            synchronous clear of window and fill (wins over shift)
//     shift          accept bit_in into the window
//     bit_in         serial data bit
//     fill           number of valid bits in the window, 0..LEN
//     hit_next       window would equal PATTERN after shifting bit_in
//     full_next      window holds LEN bits once bit_in is shifted in
//     fill_bad       fill register holds a value above LEN
module pattern_fsm_window
  import pattern_fsm_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = '0,
  localparam int            FW      = $clog2(LEN + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          shift,
  input  logic          bit_in,
  output logic [FW-1:0] fill,
  output logic          hit_next,
  output logic          full_next,
  output logic          fill_bad
);

  logic [LEN-1:0] window;
  logic [LEN-1:0] shifted;

  // The compare looks at the window as it will be after this bit, so the
  // FSM can enter HIT on the same edge the last pattern bit is accepted.
  assign shifted   = {window[LEN-2:0], bit_in};
  assign hit_next  = (shifted == PATTERN);
  assign full_next = (fill >= FW'(LEN - 1));
  assign fill_bad  = (fill > FW'(LEN));

  // Fill saturates at LEN so that ARMED/HIT keep sliding the window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window <= '0;
      fill   <= '0;
    end else if (clr) begin
      window <= '0;
      fill   <= '0;
    end else if (shift) begin
      window <= shifted;
      if (fill < FW'(LEN)) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_fsm.sv
// pattern_fsm
//   Safe serial pattern detector. Samples data_in when en && data_valid,
//   detects the LEN-bit PATTERN (MSB first) and holds match high while in
//   HIT. One-hot state register with recovery to IDLE on illegal values.
//   Optional saturating hit counter, enabled by defining PATTERN_FSM_CNT_EN;
//   without it match_cnt is tied to 0 and clear only restarts the window.
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     en             detector enable, low forces IDLE
//     clear          synchronous restart of window (and counter)
//     data_valid     qualifies data_in
//     data_in        serial bit
//     match          high while state is HIT
//     state_out      encoded state IDLE=0 FILL=1 ARMED=2 HIT=3
//     fill           bits currently in the window
//     match_cnt      saturating hit count
//     illegal        one-cycle pulse on illegal-state recovery
module pattern_fsm
  import pattern_fsm_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8,
  localparam int            FW      = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clear,
  input  logic             data_valid,
  input  logic             data_in,
  output logic             match,
  output logic [1:0]       state_out,
  output logic [FW-1:0]    fill,
  output logic [CNT_W-1:0] match_cnt,
  output logic             illegal
);

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       win_clr, win_shift;
  logic       cnt_inc, cnt_clr;
  logic       hit_next, full_next, fill_bad;

  pattern_fsm_window #(
    .LEN     (LEN),
    .PATTERN (PATTERN)
  ) u_window (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (win_clr),
    .shift     (win_shift),
    .bit_in    (data_in),
    .fill      (fill),
    .hit_next  (hit_next),
    .full_next (full_next),
    .fill_bad  (fill_bad)
  );

  // Next-state logic. Priority: illegal recovery, enable low, clear, then
  // the normal per-state behaviour. In non-overlap mode the hitting bit
  // clears the window instead of shifting it in, so the next search starts
  // from an empty window.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    win_clr   = 1'b0;
    win_shift = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    if (!$onehot(state_q) || fill_bad) begin
      state_d   = ST_IDLE;
      win_clr   = 1'b1;
      illegal_d = 1'b1;
    end else if (!en) begin
      state_d = ST_IDLE;
      win_clr = 1'b1;
      cnt_clr = clear;
    end else if (clear) begin
      state_d = ST_FILL;
      win_clr = 1'b1;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          win_clr = 1'b1;
          state_d = ST_FILL;
        end
        ST_FILL: begin
          if (data_valid) begin
            win_shift = 1'b1;
            if (full_next) begin
              if (hit_next) begin
                state_d = ST_HIT;
                cnt_inc = 1'b1;
                win_clr = !OVERLAP;
              end else begin
                state_d = ST_ARMED;
              end
            end
          end
        end
        ST_ARMED, ST_HIT: begin
          if (state_q == ST_HIT && !OVERLAP) begin
            state_d   = ST_FILL;
            win_shift = data_valid;
          end else if (data_valid) begin
            win_shift = 1'b1;
            if (hit_next) begin
              state_d = ST_HIT;
              cnt_inc = 1'b1;
              win_clr = !OVERLAP;
            end else begin
              state_d = ST_ARMED;
            end
          end else begin
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs are decoded straight from registers only.
  assign match     = (state_q == ST_HIT);
  assign state_out = encode_state(state_q);
  assign illegal   = illegal_q;

`ifdef PATTERN_FSM_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating hit counter; stops at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = cnt_inc | cnt_clr;
  assign match_cnt  = '0;
`endif

endmodule
